// File: rtl/fp_add_prestage_pkg.sv
// fp_add_prestage_pkg: shared widths, special_o encodings and shift saturation for the FP add pre-stage
package fp_add_prestage_pkg;
  localparam int DEF_SIZE_MANTISSA = 24;
  localparam int DEF_SIZE_EXPONENT = 8;
  localparam int DEF_SIZE_DATA = DEF_SIZE_MANTISSA + DEF_SIZE_EXPONENT;
  localparam int SHIFT_SAT_EXTRA = 2;
  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF = 2'b10,
    SP_NAN = 2'b11
  } special_e;
  function automatic int shift_sat(input int size_mantissa);
    return size_mantissa + SHIFT_SAT_EXTRA;
  endfunction
endpackage

// File: rtl/fp_add_prestage_unpack.sv
// fp_unpack: splits a packed operand, flushes denormals to zero and (with FP_ADD_PRESTAGE_SPECIAL_EN) classifies it
module fp_unpack
  import fp_add_prestage_pkg::*;
#(
  parameter int size_mantissa = DEF_SIZE_MANTISSA,
  parameter int size_exponent = DEF_SIZE_EXPONENT,
  parameter int size_data = DEF_SIZE_DATA
) (
  input  logic [size_data-1:0]     number,
  output logic                     sign,
  output logic [size_exponent-1:0] expo,
  output logic [size_mantissa-1:0] mant
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
  ,
  output special_e                 cls
`endif
);
  logic [size_mantissa-2:0] frac;
  logic denorm;
  assign sign = number[size_data-1];
  assign expo = number[size_data-2 -: size_exponent];
  assign frac = number[size_mantissa-2:0];
  assign denorm = expo == '0;
  assign mant = denorm ? '0 : {1'b1, frac};
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
  assign cls = &expo ? ((frac != '0) ? SP_NAN : SP_INF) : denorm ? SP_ZERO : SP_NORMAL;
`endif
endmodule

// File: rtl/fp_add_prestage.sv
// fp_add_prestage: two-stage FP add/sub pre-stage (unpack+swap, then gap/path/sign); FP_ADD_PRESTAGE_SPECIAL_EN enables special_o
module fp_add_prestage
  import fp_add_prestage_pkg::*;
#(
  parameter int size_mantissa = DEF_SIZE_MANTISSA,
  parameter int size_exponent = DEF_SIZE_EXPONENT,
  parameter int size_data = DEF_SIZE_DATA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [size_data-1:0]     a_number,
  input  logic [size_data-1:0]     b_number,
  input  logic                     sub,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [size_mantissa-1:0] m_a_number,
  output logic [size_mantissa-1:0] m_b_number,
  output logic [size_exponent:0]   exp_inter,
  output logic                     exp_difference,
  output logic [size_exponent-1:0] shift_amount,
  output logic                     close_path,
  output logic                     eff_sub,
  output logic                     sign_o,
  output logic [1:0]               special_o
);
  localparam logic [size_exponent-1:0] SAT = size_exponent'(shift_sat(size_mantissa));
  logic ua_sign, ub_sign, ub_eff, swap;
  logic [size_exponent-1:0] ua_exp, ub_exp;
  logic [size_mantissa-1:0] ua_mant, ub_mant;
  logic s1_valid, s2_valid, s2_load;
  logic s1_sign_a, s1_sign_b;
  logic [size_exponent-1:0] s1_exp_a, s1_exp_b, gap;
  logic [size_mantissa-1:0] s1_mant_a, s1_mant_b;
  logic eff_nxt, tie;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
  special_e cls_a, cls_b, s1_cls_a, s1_cls_b, sp_nxt;
`endif

  fp_unpack #(.size_mantissa(size_mantissa), .size_exponent(size_exponent), .size_data(size_data)) u_unpack_a (
    .number(a_number), .sign(ua_sign), .expo(ua_exp), .mant(ua_mant)
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
    , .cls(cls_a)
`endif
  );
  fp_unpack #(.size_mantissa(size_mantissa), .size_exponent(size_exponent), .size_data(size_data)) u_unpack_b (
    .number(b_number), .sign(ub_sign), .expo(ub_exp), .mant(ub_mant)
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
    , .cls(cls_b)
`endif
  );

  // A stage loads when empty or when its contents move on this cycle
  assign s2_load = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_valid = s2_valid;
  assign ub_eff = ub_sign ^ sub;
  // Flushed mantissas carry the fraction, so {exp, frac} is the magnitude key; ties keep operand order
  assign swap = {ub_exp, ub_mant[size_mantissa-2:0]} > {ua_exp, ua_mant[size_mantissa-2:0]};
  assign gap = s1_exp_a - s1_exp_b;
  assign eff_nxt = s1_sign_a ^ s1_sign_b;
  assign tie = (s1_exp_a == s1_exp_b) && (s1_mant_a == s1_mant_b);
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
  assign sp_nxt = (s1_cls_a == SP_NAN || s1_cls_b == SP_NAN || (s1_cls_a == SP_INF && s1_cls_b == SP_INF && eff_nxt)) ? SP_NAN :
                  (s1_cls_a == SP_INF || s1_cls_b == SP_INF) ? SP_INF :
                  (s1_cls_a == SP_ZERO && s1_cls_b == SP_ZERO) ? SP_ZERO : SP_NORMAL;
`else
  assign special_o = SP_NORMAL;
`endif

  // Stage 1: capture unpacked operands ordered larger-magnitude first, effective signs travel with them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_exp_a <= '0;
      s1_exp_b <= '0;
      s1_mant_a <= '0;
      s1_mant_b <= '0;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
      s1_cls_a <= SP_NORMAL;
      s1_cls_b <= SP_NORMAL;
`endif
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_sign_a <= swap ? ub_eff : ua_sign;
        s1_sign_b <= swap ? ua_sign : ub_eff;
        s1_exp_a <= swap ? ub_exp : ua_exp;
        s1_exp_b <= swap ? ua_exp : ub_exp;
        s1_mant_a <= swap ? ub_mant : ua_mant;
        s1_mant_b <= swap ? ua_mant : ub_mant;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
        s1_cls_a <= swap ? cls_b : cls_a;
        s1_cls_b <= swap ? cls_a : cls_b;
`endif
      end
    end
  end

  // Stage 2: exponent gap, path select and result sign, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      m_a_number <= '0;
      m_b_number <= '0;
      exp_inter <= '0;
      exp_difference <= 1'b0;
      shift_amount <= '0;
      close_path <= 1'b0;
      eff_sub <= 1'b0;
      sign_o <= 1'b0;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
      special_o <= SP_NORMAL;
`endif
    end else begin
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        m_a_number <= s1_mant_a;
        m_b_number <= s1_mant_b;
        exp_inter <= {1'b0, s1_exp_a};
        exp_difference <= gap == size_exponent'(1);
        shift_amount <= (gap > SAT) ? SAT : gap;
        close_path <= eff_nxt && (gap < size_exponent'(2));
        eff_sub <= eff_nxt;
        sign_o <= (tie && eff_nxt) ? 1'b0 : s1_sign_a;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
        special_o <= sp_nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fp_add_prestage.sv
// tb_fp_add_prestage: randomized + directed check of fp_add_prestage against an arithmetic reference model
module tb_fp_add_prestage;
  import fp_add_prestage_pkg::*;
  typedef struct packed {
    logic [23:0] ma;
    logic [23:0] mb;
    logic [8:0]  ei;
    logic        ed;
    logic [7:0]  sh;
    logic        cp;
    logic        es;
    logic        sg;
    logic [1:0]  sp;
  } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] a_number, b_number;
  logic sub, in_valid, in_ready, out_valid, out_ready;
  logic [23:0] m_a_number, m_b_number;
  logic [8:0] exp_inter;
  logic exp_difference, close_path, eff_sub, sign_o;
  logic [7:0] shift_amount;
  logic [1:0] special_o;
  res_t obs, last, r, snap;
  res_t q[$];
  logic acc, got, rdy;
  int n_cmp = 0, n_bad = 0, sent, n_out;
  logic [31:0] ops_a[4], ops_b[4];

  fp_add_prestage dut (
    .clk(clk), .rst(rst), .a_number(a_number), .b_number(b_number), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .m_a_number(m_a_number), .m_b_number(m_b_number), .exp_inter(exp_inter),
    .exp_difference(exp_difference), .shift_amount(shift_amount), .close_path(close_path),
    .eff_sub(eff_sub), .sign_o(sign_o), .special_o(special_o)
  );

  always #5 clk = ~clk;
  assign obs = {m_a_number, m_b_number, exp_inter, exp_difference, shift_amount, close_path, eff_sub, sign_o, special_o};

  // Reference: magnitudes as integers exp*2^23+frac, largest first, fields from plain arithmetic
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t m;
    longint ea, eb, fa, fb, ka, kb, gap, t;
    bit sa, sb, tb;
    ea = a[30:23];
    eb = b[30:23];
    fa = (ea == 0) ? 0 : longint'(a[22:0]);
    fb = (eb == 0) ? 0 : longint'(b[22:0]);
    sa = a[31];
    sb = b[31] ^ s;
    ka = ea * 8388608 + fa;
    kb = eb * 8388608 + fb;
    if (kb > ka) begin
      t = ea; ea = eb; eb = t;
      t = fa; fa = fb; fb = t;
      t = ka; ka = kb; kb = t;
      tb = sa; sa = sb; sb = tb;
    end
    gap = ea - eb;
    m.ma = (ea == 0) ? 24'd0 : 24'(fa + 8388608);
    m.mb = (eb == 0) ? 24'd0 : 24'(fb + 8388608);
    m.ei = 9'(ea);
    m.ed = gap == 1;
    m.sh = 8'((gap > 26) ? 26 : gap);
    m.es = sa ^ sb;
    m.cp = m.es && gap < 2;
    m.sg = (ka == kb && m.es) ? 1'b0 : sa;
    m.sp = 2'd0;
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) || (ea == 255 && eb == 255 && m.es)) m.sp = 2'd3;
    else if (ea == 255 || eb == 255) m.sp = 2'd2;
    else if (ea == 0 && eb == 0) m.sp = 2'd1;
`endif
    return m;
  endfunction

  function automatic logic [31:0] pick_b(input logic [31:0] a);
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return a;
      2: return {1'($urandom_range(0, 1)), a[30:23], 23'($urandom)};
      3: return {1'($urandom_range(0, 1)), a[30:23] + 8'($urandom_range(0, 2)) - 8'd1, 23'($urandom)};
      default: return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] want);
    n_cmp++;
    if (got_v !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got_v, want);
    end
  endtask

  // One cycle: sample 1 unit before the rising edge, score handshakes, return at the next falling edge
  task automatic step();
    res_t w;
    #4;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    rdy = in_ready;
    last = obs;
    if (got) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        w = q.pop_front();
        check("result", obs, w);
      end
    end
    if (acc) q.push_back(model(a_number, b_number, sub));
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic s, input logic ordy);
    in_valid = iv;
    a_number = a;
    b_number = b;
    sub = s;
    out_ready = ordy;
    step();
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s, output res_t res);
    drive(1'b1, a, b, s, 1'b1);
    check("accept", acc, 1);
    drive(1'b0, a, b, s, 1'b1);
    check("lat_early", got, 0);
    drive(1'b0, a, b, s, 1'b1);
    check("lat_two", got, 1);
    res = last;
  endtask

  initial begin
    in_valid = 0; a_number = 0; b_number = 0; sub = 0; out_ready = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_data", obs, 0);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b1);
    check("in_ready_after_rst", rdy, 1);

    run_one(32'h3F800000, 32'h3F400000, 1'b1, r);
    check("close_path", r, res_t'{ma: 24'h800000, mb: 24'hC00000, ei: 9'd127, ed: 1, sh: 8'd1, cp: 1, es: 1, sg: 0, sp: 0});
    run_one(32'h3FC00000, 32'h40400000, 1'b1, r);
    check("swap", r, res_t'{ma: 24'hC00000, mb: 24'hC00000, ei: 9'd128, ed: 1, sh: 8'd1, cp: 1, es: 1, sg: 1, sp: 0});
    run_one(32'h3F800000, 32'h3F800000, 1'b0, r);
    check("far_add", r, res_t'{ma: 24'h800000, mb: 24'h800000, ei: 9'd127, ed: 0, sh: 8'd0, cp: 0, es: 0, sg: 0, sp: 0});
    run_one(32'h3F800000, 32'h3F800000, 1'b1, r);
    check("cancel", r, res_t'{ma: 24'h800000, mb: 24'h800000, ei: 9'd127, ed: 0, sh: 8'd0, cp: 1, es: 1, sg: 0, sp: 0});
    run_one(32'hBF800000, 32'h3F800000, 1'b0, r);
    check("cancel_neg", r, res_t'{ma: 24'h800000, mb: 24'h800000, ei: 9'd127, ed: 0, sh: 8'd0, cp: 1, es: 1, sg: 0, sp: 0});
    run_one(32'h4F800000, 32'h3F800000, 1'b1, r);
    check("shift_sat", r, res_t'{ma: 24'h800000, mb: 24'h800000, ei: 9'd159, ed: 0, sh: 8'd26, cp: 0, es: 1, sg: 0, sp: 0});
    run_one(32'h00000001, 32'h00000000, 1'b0, r);
    check("denorm_flush", r.ma, 0);
`ifdef FP_ADD_PRESTAGE_SPECIAL_EN
    check("sp_zero", r.sp, 2'b01);
    run_one(32'h7F800000, 32'h7F800000, 1'b1, r);
    check("sp_nan", r.sp, 2'b11);
`endif

    // Backpressure: four operands, downstream stalled for several cycles
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = $urandom;
      ops_b[i] = pick_b(ops_a[i]);
    end
    sent = 0;
    n_out = 0;
    for (int k = 0; k < 5; k++) begin
      drive(sent < 4, ops_a[sent % 4], ops_b[sent % 4], 1'b1, 1'b0);
      if (acc) sent++;
      if (k == 2) snap = last;
      if (k >= 2) begin
        check("bp_in_ready_low", rdy, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold", last, snap);
      end
    end
    for (int k = 0; k < 20 && (sent < 4 || q.size() != 0); k++) begin
      drive(sent < 4, ops_a[sent % 4], ops_b[sent % 4], 1'b0, 1'b1);
      if (acc) sent++;
      if (got) n_out++;
    end
    check("bp_count", n_out, 4);

    // Reset with two operands in flight
    drive(1'b1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0);
    drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_mid_out_valid", out_valid, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 0, 0, 0, 1'b1);
      if (k == 0) check("rst_mid_in_ready", rdy, 1);
      if (got) n_out++;
    end
    check("rst_mid_no_out", n_out, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      drive($urandom_range(0, 9) < 7, ra, pick_b(ra), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
    end
    for (int k = 0; k < 10; k++) drive(1'b0, 0, 0, 0, 1'b1);
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
